// File: rtl/coolgirl_pkg.sv
// rtl/coolgirl_pkg.sv - shared constants for the CoolGirl mapper core
package coolgirl_pkg;

    // IRQ register select, formed as {cpu_addr_in[14:13], cpu_addr_in[0]}
    localparam logic [2:0] IRQ_LATCH   = 3'b100;   // $C000 even
    localparam logic [2:0] IRQ_RELOAD  = 3'b101;   // $C001 odd
    localparam logic [2:0] IRQ_DISABLE = 3'b110;   // $E000 even
    localparam logic [2:0] IRQ_ENABLE  = 3'b111;   // $E001 odd

    // Consecutive A12-low samples needed before a rise counts as a scanline
    localparam int A12_LOW_CYCLES_DEF = 3;

endpackage

// File: rtl/a12_edge_filter.sv
// rtl/a12_edge_filter.sv - PPU A12 rise filter producing scanline clock events
module a12_edge_filter
    import coolgirl_pkg::*;
#(
    parameter int A12_LOW_CYCLES = A12_LOW_CYCLES_DEF
) (
    input  logic m2,
    input  logic reset,
    input  logic ppu_a12,
    output logic clk_evt
);

    localparam int W = (A12_LOW_CYCLES < 1) ? 1 : $clog2(A12_LOW_CYCLES + 1);
    localparam logic [W-1:0] LOW_MAX = W'(A12_LOW_CYCLES);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] r_low_cnt;

    // The event fires on the edge that takes the first high sample after a long
    // enough low run; clearing the count on every high sample limits it to one
    // event per high period.
    assign clk_evt = ppu_a12 & (r_low_cnt == LOW_MAX);

    // Count consecutive low samples, saturating, and restart on any high sample
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_low_cnt <= '0;
        end else if (ppu_a12) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != LOW_MAX) begin
            r_low_cnt <= r_low_cnt + ONE;
        end
    end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// rtl/mmc3_scanline_irq.sv - MMC3-style scanline counter and active-low IRQ output
module mmc3_scanline_irq
    import coolgirl_pkg::*;
#(
    parameter bit USE_REV_A      = 1'b0,
    parameter int A12_LOW_CYCLES = A12_LOW_CYCLES_DEF
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        enable,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    output logic        irq,
    output logic [7:0]  irq_counter
);

    logic [7:0] r_counter;
    logic [7:0] r_latch;
    logic       r_reload;
    logic       r_irq_en;
    logic       r_pending;

    logic       w_clk_evt;
    logic       w_wr;
    logic [2:0] w_sel;
    logic [7:0] w_clk_counter;
    logic       w_clk_reload;
    logic       w_set_pending;
    logic       w_unused_addr;

    a12_edge_filter #(
        .A12_LOW_CYCLES (A12_LOW_CYCLES)
    ) u_a12_filter (
        .m2      (m2),
        .reset   (reset),
        .ppu_a12 (ppu_a12),
        .clk_evt (w_clk_evt)
    );

    assign w_wr          = enable & ~romsel & ~cpu_rw_in;
    assign w_sel         = {cpu_addr_in[14:13], cpu_addr_in[0]};
    assign w_unused_addr = &{1'b0, cpu_addr_in[12:1]};

    assign irq         = ~(r_pending & enable);
    assign irq_counter = r_counter;

    // Scanline clock result, computed from pre-write state so that a register
    // write on the same edge can override it afterwards
    always_comb begin
        w_clk_counter = r_counter;
        w_clk_reload  = r_reload;
        w_set_pending = 1'b0;
        if (w_clk_evt) begin
            if ((r_counter == 8'd0) || r_reload) begin
                w_clk_counter = r_latch;
                w_clk_reload  = 1'b0;
            end else begin
                w_clk_counter = r_counter - 8'd1;
            end
            if ((w_clk_counter == 8'd0) && r_irq_en) begin
                if (USE_REV_A) begin
                    w_set_pending = (r_counter != 8'd0) || (r_reload && (r_latch != 8'd0));
                end else begin
                    w_set_pending = 1'b1;
                end
            end
        end
    end

    // Apply the clock result first, then register writes, so writes win on collisions
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_counter <= 8'd0;
            r_latch   <= 8'd0;
            r_reload  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_counter <= w_clk_counter;
            r_reload  <= w_clk_reload;
            r_pending <= r_pending | w_set_pending;
            if (w_wr) begin
                case (w_sel)
                    IRQ_LATCH: r_latch <= cpu_data_in;
                    IRQ_RELOAD: begin
                        r_reload  <= 1'b1;
                        r_counter <= 8'd0;
                    end
                    IRQ_DISABLE: begin
                        r_irq_en  <= 1'b0;
                        r_pending <= 1'b0;
                    end
                    IRQ_ENABLE: r_irq_en <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb/tb_mmc3_scanline_irq.sv - self-checking bench for mmc3_scanline_irq (rev A and rev B)
module tb_mmc3_scanline_irq;

    localparam int LOWS = 3;
    localparam logic [14:0] A_C000 = 15'h4000;
    localparam logic [14:0] A_C001 = 15'h4001;
    localparam logic [14:0] A_E000 = 15'h6000;
    localparam logic [14:0] A_E001 = 15'h6001;

    logic        m2 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        romsel = 1'b1;
    logic        cpu_rw_in = 1'b1;
    logic [14:0] cpu_addr_in = 15'h0;
    logic [7:0]  cpu_data_in = 8'h0;
    logic        ppu_a12 = 1'b0;

    logic        irq_b, irq_a;
    logic [7:0]  cnt_b, cnt_a;

    int checks = 0;
    int errors = 0;

    mmc3_scanline_irq #(.USE_REV_A(1'b0), .A12_LOW_CYCLES(LOWS)) dut_b (
        .m2(m2), .reset(reset), .enable(enable), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
        .irq(irq_b), .irq_counter(cnt_b)
    );

    mmc3_scanline_irq #(.USE_REV_A(1'b1), .A12_LOW_CYCLES(LOWS)) dut_a (
        .m2(m2), .reset(reset), .enable(enable), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
        .irq(irq_a), .irq_counter(cnt_a)
    );

    always #5 m2 = ~m2;

    // Behavioural model: plain integers, unbounded low-run length
    int m_lows = 0;
    int m_cnt = 0;
    int m_latch = 0;
    bit m_reload = 0;
    bit m_en = 0;
    bit m_pend_b = 0;
    bit m_pend_a = 0;

    always @(posedge m2 or posedge reset) begin
        int old_cnt, nv;
        bit old_reload, evt;
        if (reset) begin
            m_lows = 0; m_cnt = 0; m_latch = 0; m_reload = 0;
            m_en = 0; m_pend_b = 0; m_pend_a = 0;
        end else begin
            evt = ppu_a12 && (m_lows >= LOWS);
            m_lows = ppu_a12 ? 0 : m_lows + 1;
            if (evt) begin
                old_cnt = m_cnt;
                old_reload = m_reload;
                if (old_cnt == 0 || old_reload) begin
                    nv = m_latch;
                    m_reload = 0;
                end else begin
                    nv = old_cnt - 1;
                end
                m_cnt = nv;
                if (nv == 0 && m_en) begin
                    m_pend_b = 1;
                    if (old_cnt != 0 || (old_reload && m_latch != 0)) m_pend_a = 1;
                end
            end
            if (enable && !romsel && !cpu_rw_in && cpu_addr_in[14]) begin
                case ({cpu_addr_in[13], cpu_addr_in[0]})
                    2'b00: m_latch = cpu_data_in;
                    2'b01: begin m_reload = 1; m_cnt = 0; end
                    2'b10: begin m_en = 0; m_pend_b = 0; m_pend_a = 0; end
                    default: m_en = 1;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: both DUTs against the model
    always @(negedge m2) begin
        chk("model_cnt_b", 32'(cnt_b), 32'(m_cnt));
        chk("model_cnt_a", 32'(cnt_a), 32'(m_cnt));
        chk("model_irq_b", 32'(irq_b), 32'(!(m_pend_b && enable)));
        chk("model_irq_a", 32'(irq_a), 32'(!(m_pend_a && enable)));
    end

    task automatic step();
        @(posedge m2);
        #2;
    endtask

    task automatic drive(input logic a12, input logic w, input logic [14:0] addr, input logic [7:0] data);
        ppu_a12     = a12;
        romsel      = ~w;
        cpu_rw_in   = ~w;
        cpu_addr_in = addr;
        cpu_data_in = data;
        step();
        romsel    = 1'b1;
        cpu_rw_in = 1'b1;
    endtask

    task automatic wr(input logic [14:0] addr, input logic [7:0] data);
        drive(ppu_a12, 1'b1, addr, data);
    endtask

    task automatic rise_w(input logic w, input logic [14:0] addr, input logic [7:0] data);
        repeat (LOWS) drive(1'b0, 1'b0, 15'h0, 8'h0);
        drive(1'b1, w, addr, data);
    endtask

    task automatic rise();
        rise_w(1'b0, 15'h0, 8'h0);
    endtask

    task automatic expect_out(input string name, input int c, input logic ib, input logic ia);
        chk({name, "_cnt"}, 32'(cnt_b), 32'(c));
        chk({name, "_cnt_a"}, 32'(cnt_a), 32'(c));
        chk({name, "_irq_b"}, 32'(irq_b), 32'(ib));
        chk({name, "_irq_a"}, 32'(irq_a), 32'(ia));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        step();
        step();
        expect_out("reset", 0, 1'b1, 1'b1);
        reset  = 1'b0;
        enable = 1'b1;
        step();

        // Basic countdown 3,2,1,0
        wr(A_C000, 8'h03);
        wr(A_C001, 8'h00);
        wr(A_E001, 8'h00);
        rise(); expect_out("cd3", 3, 1'b1, 1'b1);
        rise(); expect_out("cd2", 2, 1'b1, 1'b1);
        rise(); expect_out("cd1", 1, 1'b1, 1'b1);
        rise(); expect_out("cd0", 0, 1'b0, 1'b0);
        step(); step();
        expect_out("hold", 0, 1'b0, 1'b0);
        wr(A_E000, 8'h00);
        expect_out("ack", 0, 1'b1, 1'b1);

        // A12 glitch filtering
        wr(A_E001, 8'h00);
        drive(1'b0, 1'b0, 15'h0, 8'h0);
        drive(1'b0, 1'b0, 15'h0, 8'h0);
        drive(1'b1, 1'b0, 15'h0, 8'h0);
        expect_out("short_low", 0, 1'b1, 1'b1);
        rise(); expect_out("long_hi0", 3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 15'h0, 8'h0);
            expect_out("long_hi", 3, 1'b1, 1'b1);
        end
        rise(); expect_out("after_hi", 2, 1'b1, 1'b1);

        // Latch 0: rev B fires every rise, rev A never
        wr(A_C000, 8'h00);
        wr(A_C001, 8'h00);
        wr(A_E000, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wr(A_E001, 8'h00);
            rise(); expect_out("latch0", 0, 1'b0, 1'b1);
            wr(A_E000, 8'h00);
            expect_out("latch0_ack", 0, 1'b1, 1'b1);
        end

        // Same-edge collisions
        wr(A_C000, 8'h02);
        wr(A_C001, 8'h00);
        wr(A_E001, 8'h00);
        rise(); expect_out("col_a", 2, 1'b1, 1'b1);
        rise(); expect_out("col_b", 1, 1'b1, 1'b1);
        rise_w(1'b1, A_E000, 8'h00); expect_out("col_e000", 0, 1'b1, 1'b1);
        wr(A_E001, 8'h00);
        rise(); expect_out("col_c", 2, 1'b1, 1'b1);
        rise_w(1'b1, A_C001, 8'h00); expect_out("col_c001", 0, 1'b1, 1'b1);
        rise(); expect_out("col_c001_next", 2, 1'b1, 1'b1);
        wr(A_E000, 8'h00);
        rise(); expect_out("col_d", 1, 1'b1, 1'b1);
        rise_w(1'b1, A_E001, 8'h00); expect_out("col_e001", 0, 1'b1, 1'b1);
        rise_w(1'b1, A_C000, 8'h07); expect_out("col_c000", 2, 1'b1, 1'b1);
        wr(A_C001, 8'h00);
        rise(); expect_out("col_newlatch", 7, 1'b1, 1'b1);

        // Async reset while irq is low and the counter is 5
        wr(A_C000, 8'h01);
        wr(A_C001, 8'h00);
        rise(); expect_out("pre_rst1", 1, 1'b1, 1'b1);
        rise(); expect_out("pre_rst0", 0, 1'b0, 1'b0);
        wr(A_C000, 8'h05);
        rise(); expect_out("pre_rst5", 5, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        expect_out("async_rst", 0, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rise(); expect_out("post_rst", 0, 1'b1, 1'b1);
        end

        // Deselect masks irq and ignores writes; counter keeps clocking
        wr(A_E001, 8'h00);
        wr(A_C001, 8'h00);
        rise(); expect_out("sel_pend", 0, 1'b0, 1'b1);
        enable = 1'b0;
        #1;
        expect_out("desel_mask", 0, 1'b1, 1'b1);
        wr(A_E000, 8'h00);
        enable = 1'b1;
        #1;
        expect_out("resel_pend", 0, 1'b0, 1'b1);
        wr(A_E000, 8'h00);
        wr(A_C000, 8'h03);
        enable = 1'b0;
        wr(A_E001, 8'h00);
        wr(A_C000, 8'h09);
        rise(); expect_out("desel_clk3", 3, 1'b1, 1'b1);
        rise(); expect_out("desel_clk2", 2, 1'b1, 1'b1);
        rise(); expect_out("desel_clk1", 1, 1'b1, 1'b1);
        rise(); expect_out("desel_clk0", 0, 1'b1, 1'b1);
        enable = 1'b1;
        #1;
        expect_out("resel_noirq", 0, 1'b1, 1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
